// File: rtl/bcd_time_field.sv
// ============================================================================
// Module   : bcd_time_field
// Purpose  : Wrap-around time field counter with registered packed-BCD output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_time_field #(
   parameter int MODULO  = 24,
   parameter int ES_HORA = 1,
   parameter int INIT    = 0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Formato,
   input  logic       Inc,
   input  logic       Dec,
   input  logic       Tick,
   input  logic       Load,
   input  logic [6:0] Load_val,
   input  logic       Blank,
   output logic [6:0] Valor,
   output logic [7:0] Dato_out,
   output logic       Carry_out,
   output logic       Borrow_out,
   output logic       Error
);

   localparam logic [6:0] C_MOD  = 7'(MODULO);
   localparam logic [6:0] C_MAX  = 7'(MODULO - 1);
   localparam logic [6:0] C_INIT = 7'(INIT);

   logic       step_up;
   logic       step_dn;
   logic [3:0] mod12;
   logic [3:0] h12;
   logic [7:0] bcd_plain;
   logic [7:0] bcd_12h;
   logic [7:0] enc;

   assign step_up = (Inc | Tick) & ~Dec;
   assign step_dn = Dec & ~(Inc | Tick);

   // Tens digit fits in 3 bits because MODULO never exceeds 80.
   assign bcd_plain = {1'b0, 3'(Valor / 7'd10), 4'(Valor % 7'd10)};

   assign mod12   = 4'(Valor % 7'd12);
   assign h12     = (mod12 == 4'd0) ? 4'd12 : mod12;
   assign bcd_12h = {(Valor < 7'd12),
                     (h12 >= 4'd10) ? 3'd1 : 3'd0,
                     (h12 >= 4'd10) ? (h12 - 4'd10) : h12};

   always_comb begin
      enc = bcd_plain;
      if (Blank)
         enc = 8'hFF;
      else if ((ES_HORA != 0) && !Formato)
         enc = bcd_12h;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Valor      <= C_INIT;
         Dato_out   <= 8'h00;
         Carry_out  <= 1'b0;
         Borrow_out <= 1'b0;
         Error      <= 1'b0;
      end else begin
         Dato_out   <= enc;
         Carry_out  <= 1'b0;
         Borrow_out <= 1'b0;
         Error      <= 1'b0;
         if (Load) begin
            if (Load_val < C_MOD)
               Valor <= Load_val;
            else
               Error <= 1'b1;
         end else if (step_up) begin
            if (Valor == C_MAX) begin
               Valor     <= 7'd0;
               Carry_out <= 1'b1;
            end else begin
               Valor <= Valor + 7'd1;
            end
         end else if (step_dn) begin
            if (Valor == 7'd0) begin
               Valor      <= C_MAX;
               Borrow_out <= 1'b1;
            end else begin
               Valor <= Valor - 7'd1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_time_field.sv
// ============================================================================
// Module   : tb_bcd_time_field
// Purpose  : Directed self-checking bench for an hour field and a minute field
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_time_field;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // hour field (MODULO=24, ES_HORA=1)
   logic       h_rst, h_fmt, h_inc, h_dec, h_tick, h_load, h_blank;
   logic [6:0] h_lval, h_valor;
   logic [7:0] h_dato;
   logic       h_carry, h_borrow, h_err;

   // minute field (MODULO=60, ES_HORA=0)
   logic       m_rst, m_fmt, m_inc, m_dec, m_tick, m_load, m_blank;
   logic [6:0] m_lval, m_valor;
   logic [7:0] m_dato;
   logic       m_carry, m_borrow, m_err;

   int total  = 0;
   int passed = 0;

   bcd_time_field #(.MODULO(24), .ES_HORA(1), .INIT(0)) u_hour (
      .Clock(clk), .Reset(h_rst), .Formato(h_fmt), .Inc(h_inc), .Dec(h_dec),
      .Tick(h_tick), .Load(h_load), .Load_val(h_lval), .Blank(h_blank),
      .Valor(h_valor), .Dato_out(h_dato), .Carry_out(h_carry),
      .Borrow_out(h_borrow), .Error(h_err)
   );

   bcd_time_field #(.MODULO(60), .ES_HORA(0), .INIT(0)) u_min (
      .Clock(clk), .Reset(m_rst), .Formato(m_fmt), .Inc(m_inc), .Dec(m_dec),
      .Tick(m_tick), .Load(m_load), .Load_val(m_lval), .Blank(m_blank),
      .Valor(m_valor), .Dato_out(m_dato), .Carry_out(m_carry),
      .Borrow_out(m_borrow), .Error(m_err)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   // One hour-field strobe cycle; strobes are cleared right after the edge.
   task automatic h_pulse(input logic inc, input logic dec, input logic tick,
                          input logic load, input logic [6:0] val);
      h_inc = inc; h_dec = dec; h_tick = tick; h_load = load; h_lval = val;
      cyc();
      h_inc = 0; h_dec = 0; h_tick = 0; h_load = 0;
   endtask

   logic [7:0] load_vals [5] = '{8'd0, 8'd11, 8'd12, 8'd13, 8'd23};
   logic [7:0] load_exp  [5] = '{8'h92, 8'h91, 8'h12, 8'h01, 8'h11};

   initial begin
      int carries;
      h_rst = 1; h_fmt = 1; h_inc = 0; h_dec = 0; h_tick = 0; h_load = 0;
      h_lval = 0; h_blank = 0;
      m_rst = 1; m_fmt = 0; m_inc = 0; m_dec = 0; m_tick = 0; m_load = 0;
      m_lval = 0; m_blank = 0;

      cyc(); cyc();
      check("rst_valor",  {1'b0, h_valor}, 8'd0);
      check("rst_dato",   h_dato, 8'h00);
      check("rst_pulses", {5'd0, h_carry, h_borrow, h_err}, 8'd0);
      h_rst = 0; m_rst = 0;
      cyc();
      check("rel_dato", h_dato, 8'h00);

      // 24 increments in 24-hour mode
      carries = 0;
      for (int i = 0; i < 24; i++) begin
         h_pulse(1, 0, 0, 0, 7'd0);
         if (h_carry) carries++;
         check("inc_carry", {7'd0, h_carry}, (i == 23) ? 8'd1 : 8'd0);
         check("inc_valor", {1'b0, h_valor}, 8'((i + 1) % 24));
         check("inc_dato",  h_dato, 8'(((i / 10) << 4) | (i % 10)));
      end
      cyc();
      check("wrap_dato", h_dato, 8'h00);
      check("carry_count", 8'(carries), 8'd1);

      // 12-hour encoding
      h_fmt = 0;
      for (int i = 0; i < 5; i++) begin
         h_pulse(0, 0, 0, 1, 7'(load_vals[i]));
         check("h12_valor", {1'b0, h_valor}, load_vals[i]);
         cyc();
         check("h12_dato", h_dato, load_exp[i]);
      end

      // down-wrap, conflicting strobes, double up-strobe
      h_pulse(0, 0, 0, 1, 7'd0);
      h_pulse(0, 1, 0, 0, 7'd0);
      check("dec_valor",  {1'b0, h_valor}, 8'd23);
      check("dec_borrow", {7'd0, h_borrow}, 8'd1);
      h_pulse(1, 1, 0, 0, 7'd0);
      check("incdec_valor",  {1'b0, h_valor}, 8'd23);
      check("incdec_pulses", {6'd0, h_carry, h_borrow}, 8'd0);
      h_pulse(0, 0, 0, 1, 7'd5);
      h_pulse(1, 0, 1, 0, 7'd0);
      check("inctick_valor", {1'b0, h_valor}, 8'd6);

      // rejected load, then load with a simultaneous Inc
      h_pulse(0, 0, 0, 1, 7'd30);
      check("bad_load_err",   {7'd0, h_err}, 8'd1);
      check("bad_load_valor", {1'b0, h_valor}, 8'd6);
      cyc();
      check("err_clear", {7'd0, h_err}, 8'd0);
      h_fmt = 1;
      h_pulse(1, 0, 0, 1, 7'd17);
      check("load_inc_valor", {1'b0, h_valor}, 8'd17);
      check("load_inc_carry", {7'd0, h_carry}, 8'd0);
      cyc();
      check("load_inc_dato", h_dato, 8'h17);

      // minute field, plain BCD regardless of Formato
      m_load = 1; m_lval = 7'd59; cyc(); m_load = 0;
      cyc();
      check("min59_dato", m_dato, 8'h59);
      m_inc = 1; cyc(); m_inc = 0;
      check("min_wrap_valor", {1'b0, m_valor}, 8'd0);
      check("min_wrap_carry", {7'd0, m_carry}, 8'd1);
      m_blank = 1; cyc();
      check("blank_dato", m_dato, 8'hFF);
      m_blank = 0; cyc();
      check("unblank_dato", m_dato, 8'h00);
      m_load = 1; m_lval = 7'd42; cyc(); m_load = 0;
      cyc();
      check("min42_dato", m_dato, 8'h42);
      m_rst = 1; cyc(); m_rst = 0;
      check("midrst_valor", {1'b0, m_valor}, 8'd0);
      check("midrst_dato",  m_dato, 8'h00);
      m_load = 1; m_lval = 7'd59; cyc(); m_load = 0;
      m_inc = 1; m_rst = 1; cyc(); m_inc = 0; m_rst = 0;
      check("rst_over_inc_carry", {7'd0, m_carry}, 8'd0);
      check("rst_over_inc_valor", {1'b0, m_valor}, 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
